// File: rtl/rounder_mask_pipe_if.sv
// Handshake and data bundle for rounder_mask_pipe.
//
// Purpose: groups the upstream operand channel and the downstream result
// channel into one interface so the pipeline and its neighbours share a
// single port declaration.
//
// Signals:
//   in_valid / in_ready   operand handshake (upstream -> pipe)
//   sh                    unsigned right-shift amount, SHW bits
//   sig                   significand before rounding, W bits
//   out_valid / out_ready result handshake (pipe -> downstream)
//   v, w, kept            sticky-region mask, round-bit mask, sig & ~v
//   rnd, sticky, sat      round bit, sticky bit, shift saturated
//
// Modports:
//   master  the side that supplies operands and consumes results
//   slave   the pipeline itself
interface rounder_mask_pipe_if #(
    parameter int W   = 64,
    parameter int SHW = 13
);
    logic           in_valid;
    logic           in_ready;
    logic [SHW-1:0] sh;
    logic [W-1:0]   sig;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   v;
    logic [W-1:0]   w;
    logic [W-1:0]   kept;
    logic           rnd;
    logic           sticky;
    logic           sat;

    modport master (
        output in_valid, sh, sig, out_ready,
        input  in_ready, out_valid, v, w, kept, rnd, sticky, sat
    );

    modport slave (
        input  in_valid, sh, sig, out_ready,
        output in_ready, out_valid, v, w, kept, rnd, sticky, sat
    );
endinterface

// File: rtl/rounder_mask_pipe.sv
// Pipelined rounder mask generator.
//
// Purpose: from a right-shift amount and a significand, builds the
// below-shift mask v and the round-position mask w, then reduces them
// against the significand into kept bits, round bit and sticky bit.
// Two valid/ready stages sit between the alignment shifter and the
// rounding-decision logic; one operand is accepted per cycle while the
// consumer keeps up, and at most two are held while it stalls.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     rounder_mask_pipe_if.slave (operand in, result out)
//
// Stage 1 holds the masks and the raw significand; stage 2 holds the
// masks plus the reductions. The outputs are driven straight from the
// stage-2 registers, so they are stable while out_valid & !out_ready.
module rounder_mask_pipe #(
    parameter int W   = 64,
    parameter int SHW = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    rounder_mask_pipe_if.slave bus
);

    // Compare width wide enough for both the full shift amount and W itself,
    // so no shift value is ever truncated before comparison.
    localparam int IW = $clog2(W) + 2;
    localparam int CW = (SHW > IW) ? SHW : IW;

    logic [CW-1:0] sh_ext;
    logic [W-1:0]  v_c;
    logic [W-1:0]  w_c;
    logic          sat_c;

    logic          s1_valid;
    logic [W-1:0]  s1_v;
    logic [W-1:0]  s1_w;
    logic [W-1:0]  s1_sig;
    logic          s1_sat;

    logic          s2_valid;
    logic [W-1:0]  s2_v;
    logic [W-1:0]  s2_w;
    logic [W-1:0]  s2_kept;
    logic          s2_rnd;
    logic          s2_sticky;
    logic          s2_sat;

    logic          s2_load;
    logic          in_xfer;
    logic [W-1:0]  kept_c;
    logic          rnd_c;
    logic          sticky_c;

    assign sh_ext = CW'(bus.sh);

    // Bit i is below the shift point when i < sh; the round bit sits at
    // sh-1. Out-of-range shifts fall out naturally: no index reaches sh-1
    // when sh > W, and every index is below sh when sh >= W.
    always_comb begin
        v_c = '0;
        w_c = '0;
        for (int i = 0; i < W; i++) begin
            v_c[i] = (CW'(i) < sh_ext);
            w_c[i] = ((CW'(i) + CW'(1)) == sh_ext);
        end
    end

    assign sat_c = (sh_ext >= CW'(W));

    // Reductions work on the stage-1 copy so the mask build and the
    // reduce each get their own cycle.
    assign kept_c   = s1_sig & ~s1_v;
    assign rnd_c    = |(s1_sig & s1_w);
    assign sticky_c = |(s1_sig & s1_v & ~s1_w);

    // Stage 2 takes stage 1 whenever it is empty or draining this cycle.
    // in_ready depends on out_ready through s2_load; that is the only
    // combinational path from output to input handshake.
    assign s2_load      = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | s2_load;
    assign in_xfer      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_v     <= '0;
            s1_w     <= '0;
            s1_sig   <= '0;
            s1_sat   <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_v     <= v_c;
                s1_w     <= w_c;
                s1_sig   <= bus.sig;
                s1_sat   <= sat_c;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_v      <= '0;
            s2_w      <= '0;
            s2_kept   <= '0;
            s2_rnd    <= 1'b0;
            s2_sticky <= 1'b0;
            s2_sat    <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid  <= 1'b1;
                s2_v      <= s1_v;
                s2_w      <= s1_w;
                s2_kept   <= kept_c;
                s2_rnd    <= rnd_c;
                s2_sticky <= sticky_c;
                s2_sat    <= s1_sat;
            end else if (bus.out_ready && s2_valid) begin
                // Reaching here implies stage 1 is empty. Data registers
                // keep their last value; only the valid flag drops.
                s2_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.v         = s2_v;
    assign bus.w         = s2_w;
    assign bus.kept      = s2_kept;
    assign bus.rnd       = s2_rnd;
    assign bus.sticky    = s2_sticky;
    assign bus.sat       = s2_sat;

endmodule

// File: tb/tb_rounder_mask_pipe.sv
module tb_rounder_mask_pipe;

    localparam int W   = 64;
    localparam int SHW = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rounder_mask_pipe_if #(.W(W), .SHW(SHW)) bus ();

    rounder_mask_pipe #(.W(W), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] v;
        logic [W-1:0] w;
        logic [W-1:0] kept;
        logic         rnd;
        logic         sticky;
        logic         sat;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_stall = 1'b0;
    res_t prev_out;
    int   n_acc_total = 0;
    int   n_pop_total = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: masks straight from the shift arithmetic.
    function automatic res_t model(input logic [SHW-1:0] s, input logic [W-1:0] g);
        res_t        r;
        int unsigned n;
        n     = s;
        r.v   = (n >= W) ? '1 : ((64'd1 << n) - 64'd1);
        r.w   = (n == 0 || n > W) ? '0 : (64'd1 << (n - 1));
        r.sat = (n >= W);
        r.rnd    = |(g & r.w);
        r.sticky = |(g & r.v & ~r.w);
        r.kept   = g & ~r.v;
        return r;
    endfunction

    function automatic res_t cur_out();
        res_t r;
        r.v      = bus.v;
        r.w      = bus.w;
        r.kept   = bus.kept;
        r.rnd    = bus.rnd;
        r.sticky = bus.sticky;
        r.sat    = bus.sat;
        return r;
    endfunction

    task automatic cmp_res(input string tag, input res_t o, input res_t e);
        check({tag, "_v"},     o.v,    e.v);
        check({tag, "_w"},     o.w,    e.w);
        check({tag, "_kept"},  o.kept, e.kept);
        check({tag, "_flags"}, W'({o.rnd, o.sticky, o.sat}), W'({e.rnd, e.sticky, e.sat}));
    endtask

    // One cycle: drive at the falling edge, sample 1ns later, score the
    // transfers that the next rising edge will perform.
    task automatic drive_cycle(input logic iv, input logic [SHW-1:0] s, input logic [W-1:0] g,
                               input logic ordy, output logic acc, output logic popped);
        res_t o;
        res_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.sh        = s;
        bus.sig       = g;
        bus.out_ready = ordy;
        #1;
        o = cur_out();
        if (prev_stall) begin
            check("hold_valid", W'(bus.out_valid), W'(1'b1));
            cmp_res("hold", o, prev_out);
        end
        acc    = iv && bus.in_ready;
        popped = bus.out_valid && ordy;
        if (popped) begin
            n_pop_total++;
            if (exp_q.size() == 0) check("sb_underflow", W'(1'b1), W'(1'b0));
            else begin
                e = exp_q.pop_front();
                cmp_res("sb", o, e);
            end
        end
        if (acc) begin
            n_acc_total++;
            exp_q.push_back(model(s, g));
        end
        prev_stall = bus.out_valid && !ordy;
        prev_out   = o;
    endtask

    task automatic idle(input logic ordy);
        logic a, p;
        drive_cycle(1'b0, '0, '0, ordy, a, p);
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] ev, input logic [W-1:0] ew,
                              input logic [W-1:0] ek, input logic er, input logic es, input logic esat);
        res_t e;
        e.v = ev; e.w = ew; e.kept = ek; e.rnd = er; e.sticky = es; e.sat = esat;
        check({tag, "_valid"}, W'(bus.out_valid), W'(1'b1));
        cmp_res(tag, cur_out(), e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, W'(bus.out_valid), W'(1'b0));
        cmp_res(tag, cur_out(), '0);
    endtask

    initial begin
        logic a, p;
        int   c, idx, n_acc;
        logic [SHW-1:0] s;
        logic [W-1:0]   g;
        logic [SHW-1:0] bp_sh[5];
        logic [SHW-1:0] corner[5];

        bus.in_valid  = 1'b0;
        bus.sh        = '0;
        bus.sig       = '0;
        bus.out_ready = 1'b0;

        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", W'(bus.in_ready), W'(1'b1));

        // 1: zero shift passes everything through
        drive_cycle(1'b1, 13'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, a, p);
        idle(1'b1);
        check("lat_not_early", W'(bus.out_valid), W'(1'b0));
        idle(1'b1);
        expect_out("t1", 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // 2: sh=8 round bit alone, then round plus sticky
        drive_cycle(1'b1, 13'd8, 64'h80, 1'b1, a, p);
        drive_cycle(1'b1, 13'd8, 64'h181, 1'b1, a, p);
        idle(1'b1);
        expect_out("t2a", 64'hFF, 64'h80, 64'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        expect_out("t2b", 64'hFF, 64'h80, 64'h100, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        // 3: saturation
        drive_cycle(1'b1, 13'd64,    64'hDEAD_BEEF_0123_4567, 1'b1, a, p);
        drive_cycle(1'b1, 13'h1555,  64'hDEAD_BEEF_0123_4567, 1'b1, a, p);
        drive_cycle(1'b1, 13'h1FFF,  64'h0, 1'b1, a, p);
        expect_out("t3_64", '1, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        expect_out("t3_1555", '1, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        expect_out("t3_1fff", '1, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // 4: backpressure, shifts 1..5 with out_ready low for 4 cycles
        bp_sh = '{13'd1, 13'd2, 13'd3, 13'd4, 13'd5};
        idx   = 0;
        n_acc = 0;
        for (c = 0; c < 9; c++) begin
            g = {$urandom, $urandom};
            drive_cycle(idx < 5, (idx < 5) ? bp_sh[idx] : 13'd0, g, c >= 4, a, p);
            if (c == 2) begin
                check("bp_accepts", W'(n_acc), W'(2));
                check("bp_in_ready", W'(bus.in_ready), W'(1'b0));
            end
            if (c == 2 || c == 3) begin
                check("bp_stall_valid", W'(bus.out_valid), W'(1'b1));
                check("bp_stall_v", bus.v, 64'h1);
            end
            if (c >= 4) check("bp_no_gap", W'(bus.out_valid), W'(1'b1));
            if (a) begin
                idx++;
                n_acc++;
            end
        end
        check("bp_all_accepted", W'(idx), W'(5));
        check("bp_drained", W'(exp_q.size()), W'(0));

        // 5: randomized traffic
        corner = '{13'd0, 13'd63, 13'd64, 13'd65, 13'h1FFF};
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: s = SHW'($urandom_range(0, 70));
                7, 8:                s = SHW'($urandom_range(0, 8191));
                default:             s = corner[$urandom_range(0, 4)];
            endcase
            case ($urandom_range(0, 5))
                0:       g = '0;
                1:       g = '1;
                2:       g = W'($urandom_range(0, 511));
                default: g = {$urandom, $urandom};
            endcase
            drive_cycle($urandom_range(0, 3) != 0, s, g, $urandom_range(0, 3) != 0, a, p);
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
        check("rand_drained", W'(exp_q.size()), W'(0));
        check("rand_no_loss", W'(n_pop_total), W'(n_acc_total));

        // 6: reset with two operands in flight
        drive_cycle(1'b1, 13'd5, '1, 1'b0, a, p);
        drive_cycle(1'b1, 13'd6, '1, 1'b0, a, p);
        idle(1'b0);
        check("pre_rst_valid", W'(bus.out_valid), W'(1'b1));
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", W'(bus.in_ready), W'(1'b1));
        drive_cycle(1'b1, 13'd3, 64'hF0F0_F0F0_F0F0_F0FF, 1'b1, a, p);
        idle(1'b1);
        check("post_rst_not_early", W'(bus.out_valid), W'(1'b0));
        idle(1'b1);
        expect_out("post_rst", 64'h7, 64'h4, 64'hF0F0_F0F0_F0F0_F0F8, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("post_rst_drained", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
